// File: rtl/issue_exec_alu_queue.sv
// issue_exec_alu_queue
//   Issue/execute stage for the ALU lane. Each accepted reservation-station
//   bundle is evaluated by a width-generic ALU at enqueue time. The tag,
//   commands, result, flags and pass-through operand are parked in a
//   DEPTH-entry circular FIFO until downstream grants the head entry.
//
// Ports
//   clk_i, reset_i                 clock, synchronous active-high reset
//   readyRS_i                      RS presents a valid bundle
//   reservationStationVal1_i/2_i   operands A / B
//   RSVal3_i                       pass-through value
//   reservationStationCommands_i   command bits, ALU op = [4:2]
//   reservationStationTag_i        ROB tag
//   stallRS_o                      RS must hold its bundle
//   flush_i                        drop all entries and the current input
//   canGo_i                        downstream accepts the head entry
//   valid_o                        head entry present
//   executeTag_o/Commands_o/Val_o  head tag / commands / ALU result
//   executeFlags_o                 head {carry, overflow, zero, negative}
//   RSVal3_o                       head pass-through value
//   count_o                        entries held
module issue_exec_alu_queue #(
  parameter int DATA_W     = 64,
  parameter int CMD_W      = 10,
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int DEPTH      = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  readyRS_i,
  input  logic [DATA_W-1:0]     reservationStationVal1_i,
  input  logic [DATA_W-1:0]     reservationStationVal2_i,
  input  logic [DATA_W-1:0]     RSVal3_i,
  input  logic [CMD_W-1:0]      reservationStationCommands_i,
  input  logic [ROBsizeLog-1:0] reservationStationTag_i,
  output logic                  stallRS_o,
  input  logic                  flush_i,
  input  logic                  canGo_i,
  output logic                  valid_o,
  output logic [ROBsizeLog-1:0] executeTag_o,
  output logic [CMD_W-1:0]      executeCommands_o,
  output logic [DATA_W-1:0]     executeVal_o,
  output logic [3:0]            executeFlags_o,
  output logic [DATA_W-1:0]     RSVal3_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    OP_PASS_B = 3'b000,
    OP_ZERO_1 = 3'b001,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_XOR    = 3'b110,
    OP_ZERO_7 = 3'b111
  } alu_op_e;

  // ---------------------------------------------------------------- ALU
  alu_op_e           op;
  logic              is_sub;
  logic              is_arith;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   cin_ext;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;

  always_comb begin
    op         = alu_op_e'(reservationStationCommands_i[4:2]);
    a          = reservationStationVal1_i;
    is_sub     = (op == OP_SUB);
    is_arith   = (op == OP_ADD) || (op == OP_SUB);
    // Subtraction reuses the adder as A + ~B + 1 so carry means "no borrow".
    b_eff      = is_sub ? ~reservationStationVal2_i : reservationStationVal2_i;
    cin_ext    = '0;
    cin_ext[0] = is_sub;
    sum_ext    = {1'b0, a} + {1'b0, b_eff} + cin_ext;

    alu_res = '0;
    unique case (op)
      OP_PASS_B:      alu_res = reservationStationVal2_i;
      OP_ADD, OP_SUB: alu_res = sum_ext[DATA_W-1:0];
      OP_AND:         alu_res = a & reservationStationVal2_i;
      OP_OR:          alu_res = a | reservationStationVal2_i;
      OP_XOR:         alu_res = a ^ reservationStationVal2_i;
      default:        alu_res = '0;
    endcase

    alu_flags[3] = is_arith & sum_ext[DATA_W];
    alu_flags[2] = is_arith & (a[DATA_W-1] == b_eff[DATA_W-1])
                            & (sum_ext[DATA_W-1] != a[DATA_W-1]);
    alu_flags[1] = (alu_res == '0);
    alu_flags[0] = alu_res[DATA_W-1];
  end

  // --------------------------------------------------------------- FIFO
  logic [ROBsizeLog-1:0] tag_q   [DEPTH];
  logic [CMD_W-1:0]      cmd_q   [DEPTH];
  logic [DATA_W-1:0]     val_q   [DEPTH];
  logic [3:0]            flags_q [DEPTH];
  logic [DATA_W-1:0]     val3_q  [DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;
  logic                  enq;
  logic                  deq;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A full queue still accepts when the head leaves in the same cycle.
  assign stallRS_o = (count_q == FULL_CNT) & ~canGo_i;
  assign valid_o   = (count_q != '0);
  assign enq       = readyRS_i & ~stallRS_o & ~flush_i;
  assign deq       = valid_o & canGo_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_q   <= '{default: '0};
      cmd_q   <= '{default: '0};
      val_q   <= '{default: '0};
      flags_q <= '{default: '0};
      val3_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        tag_q[tail_q]   <= reservationStationTag_i;
        cmd_q[tail_q]   <= reservationStationCommands_i;
        val_q[tail_q]   <= alu_res;
        flags_q[tail_q] <= alu_flags;
        val3_q[tail_q]  <= RSVal3_i;
        tail_q          <= next_ptr(tail_q);
      end
      if (deq) begin
        head_q <= next_ptr(head_q);
      end
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign executeTag_o      = tag_q[head_q];
  assign executeCommands_o = cmd_q[head_q];
  assign executeVal_o      = val_q[head_q];
  assign executeFlags_o    = flags_q[head_q];
  assign RSVal3_o          = val3_q[head_q];
  assign count_o           = count_q;

endmodule

// File: doc/issue_exec_alu_queue.md
# issue_exec_alu_queue

Parametrised issue/execute stage for the out-of-order core's ALU lane. It accepts one operand bundle per cycle from the ALU reservation station and evaluates it with an internal width-generic ALU. The tag, commands, result, flags and pass-through third operand are buffered in a DEPTH-entry FIFO until the execution decision unit grants them. Compared with the single-register stage, it adds configurable width and depth, back-to-back throughput at 1/cycle, same-cycle enqueue+dequeue when full, a flush input and an occupancy output.

## Interface
- DATA_W, 64, operand/result width (≥2)
- CMD_W, 10, command bus width (≥5); ALU op is commands[4:2]
- ROBsize, 8, reorder-buffer entries
- ROBsizeLog, $clog2(ROBsize+1), tag width
- DEPTH, 2, result FIFO entries (≥1)
- CNT_W, $clog2(DEPTH+1), occupancy width

Ports:
- clk_i  in  1  single clock, all state updates on posedge
- reset_i  in  1  synchronous, active-high reset
- readyRS_i  in  1  RS presents a valid bundle this cycle
- reservationStationVal1_i  in  DATA_W  operand A
- reservationStationVal2_i  in  DATA_W  operand B
- RSVal3_i  in  DATA_W  pass-through value (store data / branch target)
- reservationStationCommands_i  in  CMD_W  decoded command bits
- reservationStationTag_i  in  ROBsizeLog  ROB tag
- stallRS_o  out  1  stage cannot accept; RS must hold its bundle
- flush_i  in  1  discard all buffered entries and the current input
- canGo_i  in  1  downstream accepts the head entry
- valid_o  out  1  head entry present
- executeTag_o  out  ROBsizeLog  head tag
- executeCommands_o  out  CMD_W  head commands
- executeVal_o  out  DATA_W  head ALU result
- executeFlags_o  out  4  head flags {carry, overflow, zero, negative} = bits [3:0]
- RSVal3_o  out  DATA_W  head pass-through value
- count_o  out  CNT_W  entries held

## Operation
- Enqueue (enq) = readyRS_i & ~stallRS_o & ~flush_i. Dequeue (deq) = valid_o & canGo_i & ~flush_i.
- stallRS_o = (count == DEPTH) & ~canGo_i. When full with canGo_i high, enqueue and dequeue occur in the same cycle.
- ALU is evaluated combinationally on the inputs at enqueue. The result and flags are stored with the entry, so no ALU logic sits on the output path.
- ALU op encoding:
  - 000 = B
  - 010 = A+B
  - 011 = A−B (computed as A + ~B + 1)
  - 100 = A&B
  - 101 = A|B
  - 110 = A^B
  - 001 and 111 = 0
- ALU flags:
  - negative = result[DATA_W-1]; zero = (result == 0).
  - carry = carry out of bit DATA_W-1 for add/sub, else 0.
  - overflow = signed overflow for add/sub, else 0.
- FIFO is circular with head/tail pointers that wrap modulo DEPTH. Outputs always show the head entry's stored fields, even when valid_o = 0 (don't-care contents).
- count_n = count + enq − deq; valid_o = (count != 0).
- flush_i has priority over everything: next count = 0 and pointers reset, and the same-cycle input is dropped and is not a handshake. stallRS_o is not forced high by flush.
- The commands bus and tag pass through unmodified; bits outside [4:2] are not interpreted.

## Timing
- Reset (clk_i edge with reset_i = 1): count_o = 0, valid_o = 0, pointers = 0, and all stored fields = 0, so every data/flag output reads 0. stallRS_o = 0 from the first cycle after reset.
- A reset asserted mid-operation discards all entries exactly like a flush.
- Latency: a bundle accepted at edge N appears on the outputs with valid_o = 1 after edge N (one cycle).
- Throughput: 1 entry/cycle sustained when canGo_i stays high, for any DEPTH ≥ 1.
- Output data of the head entry stays stable while valid_o & ~canGo_i.
- stallRS_o depends combinationally on canGo_i. There is no combinational path from the reservation-station inputs to any output.

## Test plan
- Reset, then readyRS_i = 1 with A=15, B=3, op=010, tag=3, canGo_i=1 -> next cycle valid_o=1, executeVal_o=18, flags=0000, tag=3; one cycle later valid_o=0.
- DEPTH=2, canGo_i=0: three back-to-back bundles -> count_o reaches 2 and stallRS_o=1. The third bundle is held; when canGo_i rises, entries drain in order at 1/cycle, and the third is accepted in the same cycle as the first dequeue.
- Arithmetic edges (DATA_W=64):
  - 0x7FFF…F + 1 -> result 0x8000…0, flags n=1, v=1, c=0.
  - 5 − 5 -> result 0, z=1, c=1.
  - 0 − 1 -> result 0xFFFF…F, n=1, c=0.
  - op=100 with A=0xF0, B=0x0F -> result 0, z=1, c=v=0.
- Pointer wrap: DEPTH=3, run 10 enqueue/dequeue cycles with random canGo_i -> output sequence of tags equals input order, and count_o matches a reference model every cycle.
- Flush with 2 entries held and readyRS_i=1 -> next cycle count_o=0, valid_o=0, and the input is not consumed (the RS bundle is resent later).
- Parameter sweep DATA_W=32, DEPTH=1, canGo_i held 1 -> full throughput with stallRS_o=0. With canGo_i=0 after one entry -> stallRS_o=1.
